// File: rtl/cp0_defs.sv
// Shared constants for the CP0 exception commit controller: ExcCodes, CP0 register
// indices, FSM encoding, exception flag bit positions and the priority-encoder result.
package cp0_defs;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int unsigned REG_BADVADDR = 8;
   localparam int unsigned REG_STATUS   = 12;
   localparam int unsigned REG_CAUSE    = 13;
   localparam int unsigned REG_EPC      = 14;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COMMIT   = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;

   localparam int unsigned FLAG_ADEL_IF = 7;
   localparam int unsigned FLAG_RI      = 6;
   localparam int unsigned FLAG_OV      = 5;
   localparam int unsigned FLAG_SYS     = 4;
   localparam int unsigned FLAG_BP      = 3;
   localparam int unsigned FLAG_ADEL_LD = 2;
   localparam int unsigned FLAG_ADES    = 1;
   localparam int unsigned FLAG_ERET    = 0;

   typedef struct packed {
      logic       hit;
      logic       is_eret;
      logic [4:0] code;
      logic       need_badvaddr;
      logic       badaddr_is_pc;
   } prio_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: picks the single winning event among a pending interrupt,
// the exception flags of the committing instruction, and ERET.
module exc_prio_enc
   import cp0_defs::*;
(
   input  logic       int_p_i,
   input  logic [7:0] exc_flags_i,
   output prio_t      prio_o
);

   always_comb begin
      prio_o     = '0;
      prio_o.hit = 1'b1;
      if (int_p_i) begin
         prio_o.code = EXC_INT;
      end else if (exc_flags_i[FLAG_ADEL_IF]) begin
         prio_o.code          = EXC_ADEL;
         prio_o.need_badvaddr = 1'b1;
         prio_o.badaddr_is_pc = 1'b1;
      end else if (exc_flags_i[FLAG_RI]) begin
         prio_o.code = EXC_RI;
      end else if (exc_flags_i[FLAG_OV]) begin
         prio_o.code = EXC_OV;
      end else if (exc_flags_i[FLAG_SYS]) begin
         prio_o.code = EXC_SYS;
      end else if (exc_flags_i[FLAG_BP]) begin
         prio_o.code = EXC_BP;
      end else if (exc_flags_i[FLAG_ADEL_LD]) begin
         prio_o.code          = EXC_ADEL;
         prio_o.need_badvaddr = 1'b1;
      end else if (exc_flags_i[FLAG_ADES]) begin
         prio_o.code          = EXC_ADES;
         prio_o.need_badvaddr = 1'b1;
      end else if (exc_flags_i[FLAG_ERET]) begin
         prio_o.is_eret = 1'b1;
      end else begin
         prio_o.hit = 1'b0;
      end
   end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt commit controller: latches the winning event in IDLE, writes CP0
// in COMMIT while flushing the pipe, then holds the front-end redirect until accepted.
module cp0_exc_ctrl
   import cp0_defs::*;
#(
   parameter int unsigned     WIDTH      = 32,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             exc_valid,
   input  logic [7:0]       exc_flags,
   input  logic [WIDTH-1:0] exc_pc,
   input  logic [WIDTH-1:0] exc_badaddr,
   input  logic             exc_in_ds,
   input  logic [5:0]       hw_int,
   input  logic [WIDTH-1:0] status_in,
   input  logic [WIDTH-1:0] cause_in,
   input  logic [WIDTH-1:0] epc_in,
   input  logic             redirect_ready,
   output logic             exc_ready,
   output logic [WIDTH-1:0] cp0_we,
   output logic [WIDTH-1:0] cp0_epc,
   output logic [WIDTH-1:0] cp0_badaddr,
   output logic [4:0]       cp0_exc_code,
   output logic             cp0_bd,
   output logic             cp0_exl,
   output logic             flush,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc
);

   logic             int_p;
   prio_t            prio;
   logic [1:0]       state_q, state_d;
   logic [4:0]       code_q, code_d;
   logic             eret_q, eret_d;
   logic             badv_q, badv_d;
   logic             bd_q, bd_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] badaddr_q, badaddr_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             unused_bits;

   assign int_p = status_in[0] & ~status_in[1] & |(status_in[15:8] & {hw_int, cause_in[9:8]});
   assign unused_bits = ^{status_in[WIDTH-1:16], status_in[7:2], cause_in[WIDTH-1:10],
                          cause_in[7:0]};

   exc_prio_enc u_prio (
      .int_p_i     (int_p),
      .exc_flags_i (exc_flags),
      .prio_o      (prio)
   );

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      eret_d    = eret_q;
      badv_d    = badv_q;
      bd_d      = bd_q;
      epc_d     = epc_q;
      badaddr_d = badaddr_q;
      target_d  = target_q;
      case (state_q)
         ST_IDLE: begin
            if (exc_valid && prio.hit) begin
               // ERET carries no EPC/BadVAddr/BD payload; zero them so COMMIT stays clean.
               state_d   = ST_COMMIT;
               code_d    = prio.code;
               eret_d    = prio.is_eret;
               badv_d    = prio.need_badvaddr;
               bd_d      = exc_in_ds & ~prio.is_eret;
               epc_d     = prio.is_eret ? '0 : (exc_in_ds ? exc_pc - WIDTH'(4) : exc_pc);
               badaddr_d = !prio.need_badvaddr ? '0 :
                           (prio.badaddr_is_pc ? exc_pc : exc_badaddr);
               target_d  = prio.is_eret ? epc_in : EXC_VECTOR;
            end
         end
         ST_COMMIT:   state_d = ST_REDIRECT;
         ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         code_q    <= '0;
         eret_q    <= 1'b0;
         badv_q    <= 1'b0;
         bd_q      <= 1'b0;
         epc_q     <= '0;
         badaddr_q <= '0;
         target_q  <= '0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         eret_q    <= eret_d;
         badv_q    <= badv_d;
         bd_q      <= bd_d;
         epc_q     <= epc_d;
         badaddr_q <= badaddr_d;
         target_q  <= target_d;
      end
   end

   always_comb begin
      cp0_we       = '0;
      cp0_epc      = '0;
      cp0_badaddr  = '0;
      cp0_exc_code = '0;
      cp0_bd       = 1'b0;
      cp0_exl      = 1'b0;
      if (state_q == ST_COMMIT) begin
         cp0_we[REG_STATUS] = 1'b1;
         if (!eret_q) begin
            cp0_we[REG_CAUSE]    = 1'b1;
            cp0_we[REG_EPC]      = 1'b1;
            cp0_we[REG_BADVADDR] = badv_q;
            cp0_epc              = epc_q;
            cp0_badaddr          = badaddr_q;
            cp0_exc_code         = code_q;
            cp0_bd               = bd_q;
            cp0_exl              = 1'b1;
         end
      end
   end

   assign exc_ready      = (state_q == ST_IDLE);
   assign flush          = (state_q == ST_COMMIT);
   assign redirect_valid = (state_q == ST_REDIRECT);
   assign redirect_pc    = redirect_valid ? target_q : '0;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus randomized events checked against an
// event-level reference model of the priority and CP0 write rules.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] VEC = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_valid;
   logic [7:0]  exc_flags;
   logic [31:0] exc_pc, exc_badaddr;
   logic        exc_in_ds;
   logic [5:0]  hw_int;
   logic [31:0] status_in, cause_in, epc_in;
   logic        redirect_ready;
   logic        exc_ready;
   logic [31:0] cp0_we, cp0_epc, cp0_badaddr;
   logic [4:0]  cp0_exc_code;
   logic        cp0_bd, cp0_exl, flush, redirect_valid;
   logic [31:0] redirect_pc;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        hit;
      logic        eret;
      logic [31:0] we;
      logic [31:0] epc;
      logic [31:0] bad;
      logic [31:0] target;
      logic [4:0]  code;
      logic        bd;
      logic        exl;
   } exp_t;

   cp0_exc_ctrl #(
      .WIDTH      (32),
      .EXC_VECTOR (VEC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .exc_valid      (exc_valid),
      .exc_flags      (exc_flags),
      .exc_pc         (exc_pc),
      .exc_badaddr    (exc_badaddr),
      .exc_in_ds      (exc_in_ds),
      .hw_int         (hw_int),
      .status_in      (status_in),
      .cause_in       (cause_in),
      .epc_in         (epc_in),
      .redirect_ready (redirect_ready),
      .exc_ready      (exc_ready),
      .cp0_we         (cp0_we),
      .cp0_epc        (cp0_epc),
      .cp0_badaddr    (cp0_badaddr),
      .cp0_exc_code   (cp0_exc_code),
      .cp0_bd         (cp0_bd),
      .cp0_exl        (cp0_exl),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Event model: rank 0..6 follows the flag bits from MSB down, interrupt beats all.
   function automatic exp_t model();
      exp_t        e;
      logic [4:0]  codes [7] = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
      logic        ip;
      int          win;
      e = '{hit: 1'b0, eret: 1'b0, we: 32'h0, epc: 32'h0, bad: 32'h0, target: VEC,
            code: 5'd0, bd: 1'b0, exl: 1'b0};
      if (!exc_valid) return e;
      ip  = status_in[0] && !status_in[1] && ((status_in[15:8] & {hw_int, cause_in[9:8]}) != 0);
      win = -1;
      for (int r = 0; r < 7; r++) if (win < 0 && exc_flags[7-r]) win = r;
      if (ip || win >= 0) begin
         e.hit  = 1'b1;
         e.code = ip ? 5'd0 : codes[win];
         e.we   = 32'h0000_7000;
         e.epc  = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
         e.bd   = exc_in_ds;
         e.exl  = 1'b1;
         if (!ip && (win == 0 || win == 5 || win == 6)) begin
            e.we[8] = 1'b1;
            e.bad   = (win == 0) ? exc_pc : exc_badaddr;
         end
      end else if (exc_flags[0]) begin
         e.hit    = 1'b1;
         e.eret   = 1'b1;
         e.we     = 32'h0000_1000;
         e.target = epc_in;
      end
      return e;
   endfunction

   task automatic drive(input logic [7:0] flags, input logic [31:0] pc, input logic [31:0] bad,
                        input logic ds, input logic [31:0] epc);
      exc_valid   = 1'b1;
      exc_flags   = flags;
      exc_pc      = pc;
      exc_badaddr = bad;
      exc_in_ds   = ds;
      epc_in      = epc;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (exc_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: ready=%b flush=%b rv=%b, required 1 0 0",
                  exc_ready, flush, redirect_valid);
      end
      n_cmp++;
      if ({cp0_we, cp0_epc, cp0_badaddr, cp0_exc_code, cp0_bd, cp0_exl, redirect_pc} !== '0) begin
         n_err++;
         $display("FAIL reset_data: we=%h epc=%h bad=%h code=%0d rpc=%h, required all 0",
                  cp0_we, cp0_epc, cp0_badaddr, cp0_exc_code, redirect_pc);
      end
   endtask

   task automatic test_ov();
      drive(8'h20, 32'h8000_0100, 32'h0, 1'b0, 32'h0);
      redirect_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      exc_valid = 1'b0;
      n_cmp++;
      if (cp0_we !== 32'h7000 || cp0_epc !== 32'h8000_0100 || cp0_exc_code !== 5'd12 ||
          cp0_exl !== 1'b1 || cp0_bd !== 1'b0 || flush !== 1'b1) begin
         n_err++;
         $display("FAIL ov_commit: we=%h epc=%h code=%0d exl=%b bd=%b flush=%b, required 7000 80000100 12 1 0 1",
                  cp0_we, cp0_epc, cp0_exc_code, cp0_exl, cp0_bd, flush);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== VEC || cp0_we !== 32'h0) begin
         n_err++;
         $display("FAIL ov_redirect: flush=%b rv=%b rpc=%h we=%h, required 0 1 %h 0",
                  flush, redirect_valid, redirect_pc, cp0_we, VEC);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (exc_ready !== 1'b1 || redirect_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ov_idle: ready=%b rv=%b, required 1 0", exc_ready, redirect_valid);
      end
   endtask

   task automatic test_adel_ld();
      drive(8'h04, 32'h8000_0200, 32'h0000_0003, 1'b1, 32'h0);
      @(posedge clk); @(negedge clk);
      exc_valid = 1'b0;
      n_cmp++;
      if (cp0_we !== 32'h7100 || cp0_badaddr !== 32'h3 || cp0_epc !== 32'h8000_01FC ||
          cp0_bd !== 1'b1 || cp0_exc_code !== 5'd4) begin
         n_err++;
         $display("FAIL adel_ld: we=%h bad=%h epc=%h bd=%b code=%0d, required 7100 3 800001fc 1 4",
                  cp0_we, cp0_badaddr, cp0_epc, cp0_bd, cp0_exc_code);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_epc_wrap();
      drive(8'h08, 32'h0, 32'h0, 1'b1, 32'h0);
      @(posedge clk); @(negedge clk);
      exc_valid = 1'b0;
      n_cmp++;
      if (cp0_epc !== 32'hFFFF_FFFC || cp0_exc_code !== 5'd9) begin
         n_err++;
         $display("FAIL epc_wrap: epc=%h code=%0d, required fffffffc 9", cp0_epc, cp0_exc_code);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_eret();
      logic [7:0] fl [2] = '{8'h01, 8'h11};
      for (int i = 0; i < 2; i++) begin
         drive(fl[i], 32'h8000_0300, 32'h0, 1'b0, 32'h8000_0040);
         @(posedge clk); @(negedge clk);
         exc_valid = 1'b0;
         n_cmp++;
         if (i == 0 && (cp0_we !== 32'h1000 || cp0_exl !== 1'b0)) begin
            n_err++;
            $display("FAIL eret_commit: we=%h exl=%b, required 1000 0", cp0_we, cp0_exl);
         end else if (i == 1 && (cp0_we !== 32'h7000 || cp0_exc_code !== 5'd8 || cp0_exl !== 1'b1)) begin
            n_err++;
            $display("FAIL eret_sys: we=%h code=%0d exl=%b, required 7000 8 1",
                     cp0_we, cp0_exc_code, cp0_exl);
         end
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (redirect_pc !== (i == 0 ? 32'h8000_0040 : VEC)) begin
            n_err++;
            $display("FAIL eret_target[%0d]: rpc=%h, required %h", i, redirect_pc,
                     (i == 0 ? 32'h8000_0040 : VEC));
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_int();
      logic [31:0] st [2] = '{32'h0000_0401, 32'h0000_0403};
      logic [4:0]  cd [2] = '{5'd0, 5'd8};
      hw_int = 6'b000001;
      for (int i = 0; i < 2; i++) begin
         status_in = st[i];
         drive(8'h10, 32'h8000_0500, 32'h0, 1'b0, 32'h0);
         @(posedge clk); @(negedge clk);
         exc_valid = 1'b0;
         n_cmp++;
         if (cp0_exc_code !== cd[i] || cp0_epc !== 32'h8000_0500 || cp0_we !== 32'h7000) begin
            n_err++;
            $display("FAIL int[%0d]: code=%0d epc=%h we=%h, required %0d 80000500 7000",
                     i, cp0_exc_code, cp0_epc, cp0_we, cd[i]);
         end
         repeat (2) @(posedge clk);
         @(negedge clk);
      end
      hw_int    = 6'b0;
      status_in = 32'h0;
   endtask

   task automatic test_backpressure();
      drive(8'h40, 32'h8000_0600, 32'h0, 1'b0, 32'h1234_5678);
      redirect_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         exc_flags = 8'($urandom) | 8'h01;
         epc_in    = $urandom;
         status_in = 32'h0000_FF01;
         hw_int    = 6'h3F;
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (redirect_valid !== 1'b1 || redirect_pc !== VEC || exc_ready !== 1'b0 ||
             cp0_we !== 32'h0) begin
            n_err++;
            $display("FAIL stall[%0d]: rv=%b rpc=%h ready=%b we=%h, required 1 %h 0 0",
                     k, redirect_valid, redirect_pc, exc_ready, cp0_we, VEC);
         end
      end
      exc_valid = 1'b0;
      status_in = 32'h0;
      hw_int    = 6'h0;
      redirect_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (exc_ready !== 1'b1 || redirect_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stall_release: ready=%b rv=%b, required 1 0", exc_ready, redirect_valid);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(8'h20, 32'h8000_0700, 32'h0, 1'b0, 32'h0);
         redirect_ready = 1'b0;
         @(posedge clk); @(negedge clk);
         exc_valid = 1'b0;
         if (i == 1) begin
            @(posedge clk); @(negedge clk);
         end
         rst_n = 1'b0;
         @(posedge clk); @(negedge clk);
         rst_n = 1'b1;
         n_cmp++;
         if (exc_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
             redirect_pc !== 32'h0 || cp0_we !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid[%0d]: ready=%b flush=%b rv=%b rpc=%h we=%h, required 1 0 0 0 0",
                     i, exc_ready, flush, redirect_valid, redirect_pc, cp0_we);
         end
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (exc_ready !== 1'b1 || cp0_we !== 32'h0 || flush !== 1'b0) begin
            n_err++;
            $display("FAIL rst_after[%0d]: ready=%b we=%h flush=%b, required 1 0 0",
                     i, exc_ready, cp0_we, flush);
         end
      end
      redirect_ready = 1'b1;
   endtask

   task automatic test_random();
      exp_t e;
      int   d;
      for (int i = 0; i < 80; i++) begin
         exc_valid   = ($urandom_range(0, 4) != 0);
         exc_flags   = 8'($urandom & $urandom & $urandom);
         exc_pc      = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         exc_badaddr = $urandom;
         exc_in_ds   = 1'($urandom);
         hw_int      = 6'($urandom);
         status_in   = $urandom;
         cause_in    = $urandom;
         epc_in      = $urandom;
         d           = $urandom_range(0, 3);
         redirect_ready = (d == 0);
         e = model();
         @(posedge clk); @(negedge clk);
         if (!e.hit) begin
            n_cmp++;
            if (exc_ready !== 1'b1 || cp0_we !== 32'h0) begin
               n_err++;
               $display("FAIL rnd_idle[%0d]: ready=%b we=%h, required 1 0", i, exc_ready, cp0_we);
            end
            continue;
         end
         exc_valid = 1'($urandom);
         exc_flags = 8'($urandom);
         status_in = $urandom;
         epc_in    = $urandom;
         n_cmp++;
         if (cp0_we !== e.we || cp0_exl !== e.exl || flush !== 1'b1 || exc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rnd_commit[%0d]: we=%h exl=%b flush=%b ready=%b, required %h %b 1 0",
                     i, cp0_we, cp0_exl, flush, exc_ready, e.we, e.exl);
         end
         if (!e.eret) begin
            n_cmp++;
            if (cp0_epc !== e.epc || cp0_badaddr !== e.bad || cp0_exc_code !== e.code ||
                cp0_bd !== e.bd) begin
               n_err++;
               $display("FAIL rnd_data[%0d]: epc=%h bad=%h code=%0d bd=%b, required %h %h %0d %b",
                        i, cp0_epc, cp0_badaddr, cp0_exc_code, cp0_bd, e.epc, e.bad, e.code, e.bd);
            end
         end
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (redirect_valid !== 1'b1 || redirect_pc !== e.target || flush !== 1'b0 ||
             cp0_we !== 32'h0) begin
            n_err++;
            $display("FAIL rnd_redirect[%0d]: rv=%b rpc=%h flush=%b we=%h, required 1 %h 0 0",
                     i, redirect_valid, redirect_pc, flush, cp0_we, e.target);
         end
         for (int k = 0; k < d; k++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (redirect_valid !== 1'b1 || redirect_pc !== e.target) begin
               n_err++;
               $display("FAIL rnd_hold[%0d.%0d]: rv=%b rpc=%h, required 1 %h",
                        i, k, redirect_valid, redirect_pc, e.target);
            end
         end
         redirect_ready = 1'b1;
         exc_valid      = 1'b0;
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (exc_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rnd_done[%0d]: ready=%b rv=%b, required 1 0", i, exc_ready, redirect_valid);
         end
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      exc_valid      = 1'b0;
      exc_flags      = 8'h0;
      exc_pc         = 32'h0;
      exc_badaddr    = 32'h0;
      exc_in_ds      = 1'b0;
      hw_int         = 6'h0;
      status_in      = 32'h0;
      cause_in       = 32'h0;
      epc_in         = 32'h0;
      redirect_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      test_ov();
      redirect_ready = 1'b1;
      test_adel_ld();
      test_epc_wrap();
      test_eret();
      test_int();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception/interrupt commit controller that drives the CP0 register file's write side. It samples the exception flags of the instruction at the commit (MEM) stage and combines them with pending interrupts from CP0 Status/Cause. It then issues the one-hot CP0 write-enable vector with EPC/BadVAddr/Cause/EXL data and redirects the front end to the exception vector, or to EPC on ERET. While an event is in flight it stalls the pipeline.

## Interface
- `WIDTH`, 32, datapath width
- `EXC_VECTOR`, 32'hBFC00380, general exception entry PC
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `exc_valid`  in  1  commit slot holds a valid instruction
- `exc_flags`  in  8  {adel_if, ri, ov, sys, bp, adel_ld, ades, eret}, MSB first
- `exc_pc`  in  WIDTH  PC of committing instruction
- `exc_badaddr`  in  WIDTH  data address for load/store faults
- `exc_in_ds`  in  1  instruction is in a branch delay slot
- `hw_int`  in  6  hardware interrupt lines
- `status_in`  in  WIDTH  CP0 Status
- `cause_in`  in  WIDTH  CP0 Cause
- `epc_in`  in  WIDTH  CP0 EPC
- `redirect_ready`  in  1  front end accepts redirect
- `exc_ready`  out  1  controller idle; pipeline may advance
- `cp0_we`  out  WIDTH  one-hot-per-register CP0 write enables
- `cp0_epc`, `cp0_badaddr`  out  WIDTH  EPC / BadVAddr write data
- `cp0_exc_code`  out  5  Cause.ExcCode write data
- `cp0_bd`, `cp0_exl`  out  1  Cause.BD / Status.EXL write data
- `flush`  out  1  kill all in-flight instructions
- `redirect_valid`  out  1  redirect request
- `redirect_pc`  out  WIDTH  redirect target

## Operation
- Interrupt pending `int_p = status[0] & ~status[1] & |(status[15:8] & {hw_int, cause[9:8]})`.
- Priority, highest first: Int(0), AdEL-fetch(4), RI(10), Ov(12), Sys(8), Bp(9), AdEL-load(4), AdES(5), then ERET. Only the winner is acted on. Events are considered only when `exc_valid=1`.
- FSM states are IDLE, COMMIT, REDIRECT, registered.
- IDLE: if an event wins, latch code, EPC, BadVAddr, BD and target, then go to COMMIT. Otherwise stay.
- COMMIT, exception case:
  - `cp0_we[13]`, `[14]`, `[12]` = 1, plus `[8]` only for AdEL/AdES.
  - `cp0_epc = in_ds ? pc-4 : pc`; `cp0_bd = in_ds`; `cp0_exl = 1`.
  - `cp0_badaddr = pc` for fetch AdEL, `exc_badaddr` for AdEL-load/AdES.
  - Target is `EXC_VECTOR`.
- COMMIT, ERET case: only `cp0_we[12]` = 1 with `cp0_exl = 0`; target is `epc_in` as sampled in IDLE.
- Also in COMMIT: `flush = 1` for one cycle; then go to REDIRECT.
- REDIRECT: hold `redirect_valid = 1` and `redirect_pc` stable until `redirect_ready`, then return to IDLE.
- `exc_ready = (state == IDLE)`. All `cp0_*` data outputs are 0 whenever `cp0_we = 0`.
- Boundary cases:
  - ERET with any exception flag: the exception wins.
  - Interrupt with any exception flag: the interrupt wins, with EPC = that instruction.
  - `int_p` asserting or inputs changing outside IDLE is ignored.
  - EPC is computed with pc-4 modulo 2^WIDTH, so 0 - 4 = 32'hFFFFFFFC.
  - Reset in any state returns to IDLE on the next edge.

## Timing
- Reset values: state IDLE, `exc_ready = 1`, all other outputs 0.
- Detection edge (IDLE→COMMIT) to CP0 write edge is 1 cycle. The CP0 registers update on the edge that ends COMMIT.
- `flush` rises in the cycle after detection and lasts exactly 1 cycle.
- `redirect_valid` first rises the cycle after COMMIT. A transfer occurs on an edge with `redirect_valid & redirect_ready`.
- Minimum event-to-event spacing is 3 cycles: IDLE, COMMIT, REDIRECT with ready high.

## Structure
- Shared package `cp0_defs`: ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12), CP0 register indices (BADVADDR=8, STATUS=12, CAUSE=13, EPC=14), FSM state encoding, flag bit positions.
- One sub-module, `exc_prio_enc`, is natural: the combinational priority encoder from {int_p, exc_flags} to {hit, is_eret, code, need_badvaddr, badaddr_is_pc}.

## Test plan
- Ov at pc 0x8000_0100, not in delay slot → COMMIT: `cp0_we` bits 12/13/14 set, `cp0_epc` = 0x8000_0100, code 12, `cp0_exl` = 1; `flush` pulses once; `redirect_pc` = 0xBFC0_0380.
- AdEL-load with badaddr 0x0000_0003 at pc 0x8000_0200 in a delay slot → `cp0_we[8]` = 1, `cp0_badaddr` = 3, `cp0_epc` = 0x8000_01FC, `cp0_bd` = 1, code 4.
- ERET with epc_in 0x8000_0040 → only `cp0_we[12]`, `cp0_exl` = 0, `redirect_pc` = 0x8000_0040; with `sys` also set → code 8 instead.
- Status = 0x0000_0401, hw_int[0] = 1, together with an Sys-flagged instruction → code 0. With Status.EXL = 1, the same stimulus gives code 8.
- `redirect_ready` held low for 5 cycles → `redirect_valid`/`redirect_pc` stable, `exc_ready` = 0, new flags ignored; ready high → IDLE next cycle.
- `rst_n` low during COMMIT and during REDIRECT → next edge: IDLE, all outputs 0, `exc_ready` = 1, no further CP0 writes.
